// File: rtl/apb4_master_bridge_if.sv
//==============================================================================
// Module      : apb4_master_bridge_if
// Description : Command/response and APB4 signal bundle for apb4_master_bridge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface apb4_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Requester side
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic                      cmd_write_i;
    logic [ADDR_WIDTH-1:0]     cmd_addr_i;
    logic [DATA_WIDTH-1:0]     cmd_wdata_i;
    logic [DATA_WIDTH/8-1:0]   cmd_wstrb_i;
    logic [2:0]                cmd_prot_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [DATA_WIDTH-1:0]     rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      rsp_timeout_o;

    // APB4 side
    logic [ADDR_WIDTH-1:0]     paddr_o;
    logic [2:0]                pprot_o;
    logic                      psel_o;
    logic                      penable_o;
    logic                      pwrite_o;
    logic [DATA_WIDTH-1:0]     pwdata_o;
    logic [DATA_WIDTH/8-1:0]   pstrb_o;
    logic [DATA_WIDTH-1:0]     prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    // The bridge itself is the APB master
    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
               cmd_prot_i, rsp_ready_i, prdata_i, pready_i, pslverr_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );

    // Environment: requester plus peripheral
    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i,
               cmd_prot_i, rsp_ready_i, prdata_i, pready_i, pslverr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
               paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

`default_nettype wire

// File: rtl/apb4_master_bridge.sv
//==============================================================================
// Module      : apb4_master_bridge
// Description : Single-outstanding command/response to APB4 initiator with timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    apb4_master_bridge_if.master  bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH:0] TIMEOUT_LIMIT = (CNT_WIDTH + 1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH:0] CNT_ONE       = {{CNT_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    wait_cnt;
    logic                    cmd_ready;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [STRB_WIDTH-1:0]   pstrb;

    logic [CNT_WIDTH:0]      cnt_next;
    logic                    timeout_hit;

    // Wait count including the current stalled cycle; abort on the Nth stall
    assign cnt_next    = {1'b0, wait_cnt} + CNT_ONE;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == TIMEOUT_LIMIT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            paddr       <= '0;
            pprot       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (bus.cmd_valid_i && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        pwrite    <= bus.cmd_write_i;
                        paddr     <= bus.cmd_addr_i;
                        pwdata    <= bus.cmd_wdata_i;
                        pstrb     <= bus.cmd_write_i ? bus.cmd_wstrb_i : '0;
                        pprot     <= bus.cmd_prot_i;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready_i) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= bus.pslverr_i;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !bus.pslverr_i) ? bus.prdata_i : '0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end else if (wait_cnt != {CNT_WIDTH{1'b1}}) begin
                        wait_cnt <= cnt_next[CNT_WIDTH-1:0];
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o   = cmd_ready;
    assign bus.rsp_valid_o   = rsp_valid;
    assign bus.rsp_rdata_o   = rsp_rdata;
    assign bus.rsp_err_o     = rsp_err;
    assign bus.rsp_timeout_o = rsp_timeout;
    assign bus.paddr_o       = paddr;
    assign bus.pprot_o       = pprot;
    assign bus.psel_o        = psel;
    assign bus.penable_o     = penable;
    assign bus.pwrite_o      = pwrite;
    assign bus.pwdata_o      = pwdata;
    assign bus.pstrb_o       = pstrb;

endmodule

`default_nettype wire

// File: tb/tb_apb4_master_bridge.sv
//==============================================================================
// Module      : tb_apb4_master_bridge
// Description : Directed self-checking bench for apb4_master_bridge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb4_master_bridge;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb4_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = addr;
        bus.cmd_wdata_i = data;
        bus.cmd_wstrb_i = strb;
        bus.cmd_prot_i  = prot;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.cmd_wstrb_i = '0;
        bus.cmd_prot_i  = '0;
        bus.rsp_ready_i = 1'b1;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b1;
        bus.pslverr_i   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
        check("rst_psel", bus.psel_o, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check("rst_paddr", bus.paddr_o, 32'h0);
        rst_n = 1'b1;
        step();
        check("idle_cmd_ready", bus.cmd_ready_o, 1'b1);

        // Zero-wait write
        issue(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001);
        step();
        bus.cmd_valid_i = 1'b0;
        check("wr_setup_psel", bus.psel_o, 1'b1);
        check("wr_setup_penable", bus.penable_o, 1'b0);
        check("wr_setup_cmd_ready", bus.cmd_ready_o, 1'b0);
        check("wr_paddr", bus.paddr_o, 32'h04);
        check("wr_pwrite", bus.pwrite_o, 1'b1);
        check("wr_pwdata", bus.pwdata_o, 32'hDEADBEEF);
        check("wr_pstrb", bus.pstrb_o, 4'hF);
        check("wr_pprot", bus.pprot_o, 3'b001);
        step();
        check("wr_access_psel", bus.psel_o, 1'b1);
        check("wr_access_penable", bus.penable_o, 1'b1);
        check("wr_access_rsp_valid", bus.rsp_valid_o, 1'b0);
        step();
        check("wr_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("wr_rsp_err", bus.rsp_err_o, 1'b0);
        check("wr_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        check("wr_resp_psel", bus.psel_o, 1'b0);
        step();
        check("wr_consumed_valid", bus.rsp_valid_o, 1'b0);
        check("wr_back_idle_ready", bus.cmd_ready_o, 1'b1);

        // Read with two wait states
        bus.pready_i = 1'b0;
        bus.prdata_i = 32'h12345678;
        issue(1'b0, 32'h08, 32'h0, 4'hF, 3'b010);
        step();
        bus.cmd_valid_i = 1'b0;
        check("rd_pstrb_zero", bus.pstrb_o, 4'h0);
        check("rd_pwrite", bus.pwrite_o, 1'b0);
        step();
        check("rd_access1_penable", bus.penable_o, 1'b1);
        step();
        check("rd_access2_penable", bus.penable_o, 1'b1);
        check("rd_access2_paddr", bus.paddr_o, 32'h08);
        step();
        check("rd_access3_psel", bus.psel_o, 1'b1);
        check("rd_access3_rsp_valid", bus.rsp_valid_o, 1'b0);
        bus.pready_i = 1'b1;
        step();
        check("rd_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("rd_rsp_rdata", bus.rsp_rdata_o, 32'h12345678);
        check("rd_rsp_err", bus.rsp_err_o, 1'b0);
        step();

        // Read terminated with a slave error
        bus.pslverr_i = 1'b1;
        bus.prdata_i  = 32'hFFFFFFFF;
        issue(1'b0, 32'h0C, 32'h0, 4'h0, 3'b000);
        step();
        bus.cmd_valid_i = 1'b0;
        step();
        step();
        check("err_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("err_rsp_err", bus.rsp_err_o, 1'b1);
        check("err_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        check("err_rsp_timeout", bus.rsp_timeout_o, 1'b0);
        bus.pslverr_i = 1'b0;
        step();

        // Timeout: pready held low for the whole access
        bus.pready_i = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
        step();
        bus.cmd_valid_i = 1'b0;
        step();
        step();
        step();
        step();
        check("to_4th_wait_psel", bus.psel_o, 1'b1);
        check("to_4th_wait_rsp_valid", bus.rsp_valid_o, 1'b0);
        step();
        check("to_psel_dropped", bus.psel_o, 1'b0);
        check("to_penable_dropped", bus.penable_o, 1'b0);
        check("to_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("to_rsp_err", bus.rsp_err_o, 1'b1);
        check("to_rsp_timeout", bus.rsp_timeout_o, 1'b1);
        check("to_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        step();
        bus.pready_i = 1'b1;
        issue(1'b1, 32'h24, 32'h0BADF00D, 4'h3, 3'b000);
        step();
        bus.cmd_valid_i = 1'b0;
        check("after_to_pstrb", bus.pstrb_o, 4'h3);
        step();
        step();
        check("after_to_rsp_valid", bus.rsp_valid_o, 1'b1);
        check("after_to_rsp_err", bus.rsp_err_o, 1'b0);
        check("after_to_rsp_timeout", bus.rsp_timeout_o, 1'b0);
        step();

        // Response back-pressure with a new command already waiting
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = 32'hCAFEF00D;
        issue(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
        step();
        step();
        step();
        check("bp_rsp_rdata", bus.rsp_rdata_o, 32'hCAFEF00D);
        bus.prdata_i = 32'h55555555;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_rsp_valid", bus.rsp_valid_o, 1'b1);
            check("bp_hold_rdata", bus.rsp_rdata_o, 32'hCAFEF00D);
            check("bp_hold_cmd_ready", bus.cmd_ready_o, 1'b0);
            check("bp_hold_psel", bus.psel_o, 1'b0);
        end
        bus.rsp_ready_i = 1'b1;
        step();
        check("bp_release_valid", bus.rsp_valid_o, 1'b0);
        check("bp_release_ready", bus.cmd_ready_o, 1'b1);
        check("bp_release_psel", bus.psel_o, 1'b0);
        step();
        bus.cmd_valid_i = 1'b0;
        check("bp_next_psel", bus.psel_o, 1'b1);
        step();
        step();
        check("bp_next_rdata", bus.rsp_rdata_o, 32'h55555555);
        step();

        // Asynchronous reset during ACCESS
        bus.pready_i = 1'b0;
        issue(1'b1, 32'h40, 32'h11112222, 4'hF, 3'b000);
        step();
        bus.cmd_valid_i = 1'b0;
        step();
        check("ar_in_access", bus.penable_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_psel_async", bus.psel_o, 1'b0);
        check("ar_penable_async", bus.penable_o, 1'b0);
        check("ar_rsp_valid_async", bus.rsp_valid_o, 1'b0);
        step();
        rst_n        = 1'b1;
        bus.pready_i = 1'b1;
        step();
        check("ar_post_cmd_ready", bus.cmd_ready_o, 1'b1);
        step();
        check("ar_post_psel", bus.psel_o, 1'b0);
        check("ar_post_rsp_valid", bus.rsp_valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
